gauss_array_driver: RTL and testbench

Edge driver and result collector for the systolic GF(2^GF_BIT) processor array used for Gaussian elimination and matrix operations. It accepts one command and M matrix rows from upstream, then drives the top edge of an N-column processor array with column-skewed row data, control and op codes. It generates the start and finish framing the processors expect, collects the bottom-edge outputs, deskews them, and emits M aligned result rows.

---
 rtl/gauss_array_driver.sv | 229 ++++++++++++++++++++++
 tb/tb_gauss_array_driver.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gauss_array_driver.sv
`default_nettype none
// ============================================================================
// Module   : gauss_array_driver
// Purpose  : Edge driver and result collector for a systolic GF(2^GF_BIT)
//            processor array. It accepts one command and M rows, drives the
//            array top edge with column-skewed data/start/finish/op, appends
//            M flush rows, and then deskews the bottom-edge outputs into M
//            aligned result rows.
// Ports    : clk, rst_n               clock, async active-low reset
//            cmd_valid/ready/op/functionA   job command handshake
//            row_valid/ready/data     upstream rows (FEED only, no stall)
//            arr_data/start/finish/op/functionA   array top-edge drive
//            arr_result               array bottom-edge data
//            res_valid/res_data       aligned result rows
//            busy, done, err          status
// Revision : 1.0 - initial release
// ============================================================================
module gauss_array_driver #(
  parameter int GF_BIT      = 4,
  parameter int OP_CODE_LEN = 4,
  parameter int N           = 4,
  parameter int M           = 4,
  parameter int LAT         = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [OP_CODE_LEN-1:0]   cmd_op,
  input  logic                     cmd_functionA,
  input  logic                     row_valid,
  output logic                     row_ready,
  input  logic [N*GF_BIT-1:0]      row_data,
  output logic [N*GF_BIT-1:0]      arr_data,
  output logic [N-1:0]             arr_start,
  output logic [N-1:0]             arr_finish,
  output logic [N*OP_CODE_LEN-1:0] arr_op,
  output logic                     arr_functionA,
  input  logic [N*GF_BIT-1:0]      arr_result,
  output logic                     res_valid,
  output logic [N*GF_BIT-1:0]      res_data,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int CW = (M > 1) ? $clog2(M) : 1;
  // Collect token delay from the column-0 slot to res_valid.
  localparam int TD = LAT + N;
  localparam int SW = GF_BIT + OP_CODE_LEN + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            row_cnt_q, row_cnt_d;
  logic [CW-1:0]            res_cnt_q;
  logic [OP_CODE_LEN-1:0]   op_q;
  logic                     fa_q;
  logic                     err_q, err_d;
  logic                     accept;
  logic                     last_row;

  logic [N*GF_BIT-1:0]      inj_data;
  logic                     inj_start, inj_finish, inj_tok;

  logic [N*GF_BIT-1:0]      slot_data_q;
  logic                     slot_start_q, slot_finish_q;
  logic [OP_CODE_LEN-1:0]   slot_op_q;
  // tok_q[0] is the column-0 slot; tok_q[TD] is res_valid.
  logic [TD:0]              tok_q;

  assign accept    = (state_q == IDLE) && cmd_valid;
  assign last_row  = (row_cnt_q == CW'(M - 1));
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign row_ready = (state_q == FEED);
  assign res_valid = tok_q[TD];
  assign err       = err_q;
  assign arr_functionA = fa_q;

  always_comb begin
    state_d    = state_q;
    row_cnt_d  = row_cnt_q;
    err_d      = err_q;
    inj_data   = '0;
    inj_start  = 1'b0;
    inj_finish = 1'b0;
    inj_tok    = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d   = FEED;
          row_cnt_d = '0;
          err_d     = 1'b0;
        end
      end
      FEED: begin
        // The array cannot stall: a missing row becomes a zero row.
        inj_data  = row_valid ? row_data : '0;
        inj_start = (row_cnt_q == '0);
        if (!row_valid) begin
          err_d = 1'b1;
        end
        if (last_row) begin
          state_d   = FLUSH;
          row_cnt_d = '0;
        end else begin
          row_cnt_d = row_cnt_q + CW'(1);
        end
      end
      FLUSH: begin
        inj_finish = 1'b1;
        inj_tok    = 1'b1;
        if (last_row) begin
          state_d   = DRAIN;
          row_cnt_d = '0;
        end else begin
          row_cnt_d = row_cnt_q + CW'(1);
        end
      end
      DRAIN: begin
        if (res_valid && (res_cnt_q == CW'(M - 1))) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      row_cnt_q     <= '0;
      res_cnt_q     <= '0;
      err_q         <= 1'b0;
      op_q          <= '0;
      fa_q          <= 1'b0;
      slot_data_q   <= '0;
      slot_start_q  <= 1'b0;
      slot_finish_q <= 1'b0;
      slot_op_q     <= '0;
      tok_q         <= '0;
    end else begin
      state_q       <= state_d;
      row_cnt_q     <= row_cnt_d;
      err_q         <= err_d;
      if (accept) begin
        op_q      <= cmd_op;
        fa_q      <= cmd_functionA;
        res_cnt_q <= '0;
      end else if (res_valid) begin
        res_cnt_q <= res_cnt_q + CW'(1);
      end
      slot_data_q   <= inj_data;
      slot_start_q  <= inj_start;
      slot_finish_q <= inj_finish;
      // Op follows the job value continuously so it is never zeroed in IDLE.
      slot_op_q     <= op_q;
      tok_q         <= {tok_q[TD-1:0], inj_tok};
    end
  end

  // Column j sees the column-0 slot delayed by j further cycles.
  for (genvar j = 0; j < N; j++) begin : g_skew
    logic [SW-1:0] col_slot;
    logic [SW-1:0] col_out;
    assign col_slot = {slot_data_q[j*GF_BIT +: GF_BIT], slot_op_q,
                       slot_start_q, slot_finish_q};
    if (j == 0) begin : g_direct
      assign col_out = col_slot;
    end else begin : g_delay
      logic [SW-1:0] sr_q [j];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < j; k++) sr_q[k] <= '0;
        end else begin
          sr_q[0] <= col_slot;
          for (int k = 1; k < j; k++) sr_q[k] <= sr_q[k-1];
        end
      end
      assign col_out = sr_q[j-1];
    end
    assign arr_data[j*GF_BIT +: GF_BIT]           = col_out[SW-1 -: GF_BIT];
    assign arr_op[j*OP_CODE_LEN +: OP_CODE_LEN]   = col_out[2 +: OP_CODE_LEN];
    assign arr_start[j]                           = col_out[1];
    assign arr_finish[j]                          = col_out[0];
  end

  // Column j result is delayed N-1-j cycles, undoing the input skew, then
  // captured when the collect token is one stage short of res_valid.
  for (genvar j = 0; j < N; j++) begin : g_deskew
    localparam int DD = N - 1 - j;
    logic [GF_BIT-1:0] col_in;
    logic [GF_BIT-1:0] col_dly;
    logic [GF_BIT-1:0] res_col_q;
    assign col_in = arr_result[j*GF_BIT +: GF_BIT];
    if (DD == 0) begin : g_direct
      assign col_dly = col_in;
    end else begin : g_delay
      logic [GF_BIT-1:0] sr_q [DD];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < DD; k++) sr_q[k] <= '0;
        end else begin
          sr_q[0] <= col_in;
          for (int k = 1; k < DD; k++) sr_q[k] <= sr_q[k-1];
        end
      end
      assign col_dly = sr_q[DD-1];
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        res_col_q <= '0;
      end else if (tok_q[TD-1]) begin
        res_col_q <= col_dly;
      end
    end
    assign res_data[j*GF_BIT +: GF_BIT] = res_col_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_gauss_array_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_gauss_array_driver
// Purpose  : Self-checking bench for gauss_array_driver with a processor-array
//            stand-in (loopback or register readback) and a cycle-indexed
//            reference of what each column should see and return.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gauss_array_driver;

  localparam int GF_BIT = 4;
  localparam int OPL    = 4;
  localparam int N      = 4;
  localparam int M      = 4;
  localparam int LAT    = 4;
  localparam int W      = N * GF_BIT;
  localparam int DONE_C = 2*M + LAT + N + 1;

  localparam int GF2  = 8;
  localparam int N2   = 2;
  localparam int M2   = 3;
  localparam int LAT2 = 3;
  localparam int W2   = N2 * GF2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [OPL-1:0]   cmd_op = '0;
  logic             cmd_functionA = 1'b0;
  logic             row_valid = 1'b0;
  logic             row_ready;
  logic [W-1:0]     row_data = '0;
  logic [W-1:0]     arr_data;
  logic [N-1:0]     arr_start, arr_finish;
  logic [N*OPL-1:0] arr_op;
  logic             arr_functionA;
  logic [W-1:0]     arr_result;
  logic             res_valid;
  logic [W-1:0]     res_data;
  logic             busy, done, err;

  gauss_array_driver #(.GF_BIT(GF_BIT), .OP_CODE_LEN(OPL), .N(N), .M(M), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_functionA(cmd_functionA),
    .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
    .arr_data(arr_data), .arr_start(arr_start), .arr_finish(arr_finish),
    .arr_op(arr_op), .arr_functionA(arr_functionA), .arr_result(arr_result),
    .res_valid(res_valid), .res_data(res_data),
    .busy(busy), .done(done), .err(err)
  );

  // Second instance in the wide-element, narrow-array configuration.
  logic              cmd_valid2 = 1'b0;
  logic              cmd_ready2;
  logic [OPL-1:0]    cmd_op2 = '0;
  logic              row_valid2 = 1'b0;
  logic              row_ready2;
  logic [W2-1:0]     row_data2 = '0;
  logic [W2-1:0]     arr_data2;
  logic [N2-1:0]     arr_start2, arr_finish2;
  logic [N2*OPL-1:0] arr_op2;
  logic              arr_functionA2;
  logic [W2-1:0]     arr_result2;
  logic              res_valid2;
  logic [W2-1:0]     res_data2;
  logic              busy2, done2, err2;

  gauss_array_driver #(.GF_BIT(GF2), .OP_CODE_LEN(OPL), .N(N2), .M(M2), .LAT(LAT2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_op(cmd_op2),
    .cmd_functionA(1'b0),
    .row_valid(row_valid2), .row_ready(row_ready2), .row_data(row_data2),
    .arr_data(arr_data2), .arr_start(arr_start2), .arr_finish(arr_finish2),
    .arr_op(arr_op2), .arr_functionA(arr_functionA2), .arr_result(arr_result2),
    .res_valid(res_valid2), .res_data(res_data2),
    .busy(busy2), .done(done2), .err(err2)
  );

  // ---------------- processor-array stand-ins ----------------
  // mode 0: data_out = data_in delayed LAT.
  // mode 1: each column stores the rows it receives after start and returns
  //         them in order, one per finish slot, after LAT cycles.
  logic             model_mode = 1'b0;
  logic [W-1:0]     lat_sh [LAT];
  logic [GF_BIT-1:0] store [N][M];
  int               wr_idx [N];
  int               rd_idx [N];
  logic [W-1:0]     arr_in_now;

  always_comb begin
    arr_in_now = arr_data;
    if (model_mode) begin
      arr_in_now = '0;
      for (int j = 0; j < N; j++)
        if (arr_finish[j] && rd_idx[j] < M)
          arr_in_now[j*GF_BIT +: GF_BIT] = store[j][rd_idx[j]];
    end
  end

  always @(posedge clk) begin
    lat_sh[0] <= arr_in_now;
    for (int k = 1; k < LAT; k++) lat_sh[k] <= lat_sh[k-1];
    for (int j = 0; j < N; j++) begin
      if (arr_start[j]) begin
        store[j][0] <= arr_data[j*GF_BIT +: GF_BIT];
        wr_idx[j]   <= 1;
        rd_idx[j]   <= 0;
      end else if (arr_finish[j]) begin
        rd_idx[j] <= rd_idx[j] + 1;
      end else if (wr_idx[j] < M) begin
        store[j][wr_idx[j]] <= arr_data[j*GF_BIT +: GF_BIT];
        wr_idx[j]           <= wr_idx[j] + 1;
      end
    end
  end
  assign arr_result = lat_sh[LAT-1];

  logic [W2-1:0] lat2_sh [LAT2];
  always @(posedge clk) begin
    lat2_sh[0] <= arr_data2;
    for (int k = 1; k < LAT2; k++) lat2_sh[k] <= lat2_sh[k-1];
  end
  assign arr_result2 = lat2_sh[LAT2-1];

  // ---------------- scoreboard state ----------------
  int             n_vec = 0;
  int             n_bad = 0;
  logic [OPL-1:0] prev_op = '0;
  logic [W-1:0]   exp_res = '0;
  logic           exp_err = 1'b0;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  // One job from accept (cycle 0) to the first IDLE cycle after done.
  task automatic run_job(input logic [OPL-1:0] op, input logic fa, input int drop,
                         input logic mode, input logic hold,
                         input logic [OPL-1:0] next_op, input logic next_fa,
                         input logic fixed_rows);
    logic [W-1:0]     rows [M];
    logic [W-1:0]     eff  [M];
    logic [W-1:0]     e_data;
    logic [N-1:0]     e_start, e_fin;
    logic [N*OPL-1:0] e_op;
    logic             e_rv, e_done, e_busy, e_err;
    int               i;
    for (int k = 0; k < M; k++) begin
      if (fixed_rows) begin
        for (int j = 0; j < N; j++) rows[k][j*GF_BIT +: GF_BIT] = GF_BIT'(k + 1);
      end else begin
        rows[k] = W'($urandom);
      end
      eff[k] = (k == drop) ? '0 : rows[k];
    end
    model_mode    = mode;
    cmd_valid     = 1'b1;
    cmd_op        = op;
    cmd_functionA = fa;
    row_valid     = 1'b0;
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL accept_ready: cmd_ready=%b expected 1", cmd_ready);
    end
    n_vec++;
    if (err !== exp_err) begin
      n_bad++; $display("FAIL err_before_accept: err=%b expected %b", err, exp_err);
    end
    for (int c = 1; c <= DONE_C + 1; c++) begin
      @(posedge clk); #1;
      if (hold) begin
        cmd_valid = 1'b1; cmd_op = next_op; cmd_functionA = next_fa;
      end else begin
        cmd_valid = 1'b0; cmd_op = OPL'($urandom); cmd_functionA = 1'($urandom);
      end
      if (c <= M) begin
        row_valid = (c - 1 != drop);
        row_data  = row_valid ? rows[c-1] : W'($urandom);
      end else begin
        row_valid = 1'b0;
        row_data  = W'($urandom);
      end
      e_data = '0; e_start = '0; e_fin = '0; e_op = '0;
      for (int j = 0; j < N; j++) begin
        i = c - 1 - j;
        if (i >= 1 && i <= M) begin
          e_data[j*GF_BIT +: GF_BIT] = eff[i-1][j*GF_BIT +: GF_BIT];
          e_start[j] = (i == 1);
        end
        if (i >= M + 1 && i <= 2*M) e_fin[j] = 1'b1;
        e_op[j*OPL +: OPL] = (i >= 1) ? op : prev_op;
      end
      i      = c - 1 - LAT - N;
      e_rv   = (i >= M + 1 && i <= 2*M);
      if (e_rv) exp_res = mode ? eff[i-M-1] : '0;
      e_done = (c == DONE_C);
      e_busy = (c <= DONE_C);
      e_err  = (drop >= 0 && c >= 2 + drop);

      n_vec++;
      if (arr_data !== e_data) begin
        n_bad++; $display("FAIL arr_data c=%0d: got %h expected %h", c, arr_data, e_data);
      end
      n_vec++;
      if (arr_start !== e_start) begin
        n_bad++; $display("FAIL arr_start c=%0d: got %b expected %b", c, arr_start, e_start);
      end
      n_vec++;
      if (arr_finish !== e_fin) begin
        n_bad++; $display("FAIL arr_finish c=%0d: got %b expected %b", c, arr_finish, e_fin);
      end
      n_vec++;
      if (arr_op !== e_op) begin
        n_bad++; $display("FAIL arr_op c=%0d: got %h expected %h", c, arr_op, e_op);
      end
      n_vec++;
      if (arr_functionA !== fa) begin
        n_bad++; $display("FAIL arr_functionA c=%0d: got %b expected %b", c, arr_functionA, fa);
      end
      n_vec++;
      if (row_ready !== (c <= M)) begin
        n_bad++; $display("FAIL row_ready c=%0d: got %b expected %b", c, row_ready, (c <= M));
      end
      n_vec++;
      if ({busy, cmd_ready} !== {e_busy, ~e_busy}) begin
        n_bad++; $display("FAIL busy_ready c=%0d: got %b%b expected %b%b", c, busy, cmd_ready, e_busy, ~e_busy);
      end
      n_vec++;
      if (res_valid !== e_rv) begin
        n_bad++; $display("FAIL res_valid c=%0d: got %b expected %b", c, res_valid, e_rv);
      end
      n_vec++;
      if (res_data !== exp_res) begin
        n_bad++; $display("FAIL res_data c=%0d: got %h expected %h", c, res_data, exp_res);
      end
      n_vec++;
      if (done !== e_done) begin
        n_bad++; $display("FAIL done c=%0d: got %b expected %b", c, done, e_done);
      end
      n_vec++;
      if (err !== e_err) begin
        n_bad++; $display("FAIL err c=%0d: got %b expected %b", c, err, e_err);
      end
    end
    row_valid = 1'b0;
    prev_op   = op;
    exp_err   = (drop >= 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({arr_data, arr_start, arr_finish, arr_op, arr_functionA} !== '0) begin
      n_bad++; $display("FAIL reset_arr: got %h expected 0", {arr_data, arr_start, arr_finish, arr_op, arr_functionA});
    end
    n_vec++;
    if ({res_valid, res_data, done, err, busy, row_ready} !== '0) begin
      n_bad++; $display("FAIL reset_status: got %h expected 0", {res_valid, res_data, done, err, busy, row_ready});
    end
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run_job(OPL'($urandom), 1'b0, -1, 1'b0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_random_rows();
    for (int n = 0; n < 3; n++)
      run_job(OPL'($urandom), 1'($urandom), -1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_dropped_row();
    run_job(OPL'($urandom), 1'($urandom), int'($urandom_range(0, M-1)), 1'b1, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [OPL-1:0] op2;
    logic           fa2;
    op2 = OPL'($urandom);
    fa2 = 1'($urandom);
    run_job(OPL'($urandom), ~fa2, 1, 1'b1, 1'b1, op2, fa2, 1'b0);
    run_job(op2, fa2, -1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midflush();
    cmd_valid     = 1'b1;
    cmd_op        = 4'hA;
    cmd_functionA = 1'b1;
    for (int c = 1; c <= M + 2; c++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      row_valid = (c <= M) && (c != 2);
      row_data  = W'($urandom);
    end
    n_vec++;
    if ({busy, arr_finish[0], err} !== 3'b111) begin
      n_bad++; $display("FAIL midflush_state: got %b expected 111", {busy, arr_finish[0], err});
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({arr_data, arr_start, arr_finish, arr_op, arr_functionA} !== '0) begin
      n_bad++; $display("FAIL midreset_arr: got %h expected 0", {arr_data, arr_start, arr_finish, arr_op, arr_functionA});
    end
    n_vec++;
    if ({res_valid, res_data, done, err, busy, row_ready, cmd_ready} !== 1) begin
      n_bad++; $display("FAIL midreset_status: got %h expected 1", {res_valid, res_data, done, err, busy, row_ready, cmd_ready});
    end
    row_valid = 1'b0;
    @(posedge clk); #1;
    rst_n   = 1'b1;
    prev_op = '0;
    exp_res = '0;
    exp_err = 1'b0;
    @(posedge clk); #1;
    run_job(OPL'($urandom), 1'b1, -1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_small_config();
    int cyc;
    int done_at;
    int rv_cnt;
    logic rv_at_done;
    logic [W2-1:0] res_at_done;
    cyc = 0; done_at = -1; rv_cnt = 0; rv_at_done = 1'b0; res_at_done = '1;
    n_vec++;
    if (cmd_ready2 !== 1'b1) begin
      n_bad++; $display("FAIL small_ready: got %b expected 1", cmd_ready2);
    end
    cmd_valid2 = 1'b1;
    cmd_op2    = OPL'($urandom);
    while (cyc < 60 && done_at < 0) begin
      @(posedge clk); #1;
      cyc++;
      cmd_valid2 = 1'b0;
      row_valid2 = (cyc <= M2);
      row_data2  = W2'($urandom);
      if (res_valid2) rv_cnt++;
      if (done2) begin
        done_at     = cyc;
        rv_at_done  = res_valid2;
        res_at_done = res_data2;
      end
    end
    row_valid2 = 1'b0;
    n_vec++;
    if (done_at != 2*M2 + LAT2 + N2 + 1) begin
      n_bad++; $display("FAIL small_latency: got %0d expected %0d", done_at, 2*M2 + LAT2 + N2 + 1);
    end
    n_vec++;
    if (rv_cnt != M2) begin
      n_bad++; $display("FAIL small_res_count: got %0d expected %0d", rv_cnt, M2);
    end
    n_vec++;
    if ({rv_at_done, res_at_done} !== {1'b1, {W2{1'b0}}}) begin
      n_bad++; $display("FAIL small_done_res: got %b/%h expected 1/0", rv_at_done, res_at_done);
    end
    @(posedge clk); #1;
    n_vec++;
    if ({busy2, cmd_ready2, res_valid2} !== 3'b010) begin
      n_bad++; $display("FAIL small_idle: got %b expected 010", {busy2, cmd_ready2, res_valid2});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random_rows();
    test_dropped_row();
    test_back_to_back();
    test_reset_midflush();
    test_small_config();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
